// File: rtl/adc_capture.sv
// Triggered capture of the 8-bit AD converter into a ring buffer, read back by logical index.
// Optional forced trigger after a WAIT_TRIG timeout: define AUTO_TRIG_EN.
module adc_capture #(
  parameter int ADDR_W        = 10,
  parameter int PRE_TRIG      = 256,
  parameter int AUTO_TRIG_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              adclk,
  input  logic [7:0]        addata,
  input  logic              arm,
  input  logic [7:0]        trig_level,
  input  logic              trig_slope,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              auto_trig,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_WAIT, ST_POST, ST_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] trig_pos_reg, trig_pos_next;
  logic              auto_trig_reg, auto_trig_next;
  logic [7:0]        s0_reg, s1_reg;
  logic [7:0]        rd_data_reg;
  logic              rd_valid_reg;
  logic              wr_en;
  logic              level_hit;
  logic              force_trig;
  logic              rd_accept;
  logic [ADDR_W-1:0] rd_phys;

  logic [7:0] mem [DEPTH];

  assign adclk     = clk;
  assign busy      = (state_reg == ST_ARM) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
  assign done      = (state_reg == ST_DONE);
  assign trig_pos  = trig_pos_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;

  assign level_hit = trig_slope ? ((s1_reg > trig_level) && (s0_reg <= trig_level))
                                : ((s1_reg < trig_level) && (s0_reg >= trig_level));

`ifdef AUTO_TRIG_EN
  localparam int AW = $clog2(AUTO_TRIG_CYC + 1);
  logic [AW-1:0] auto_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_reg <= '0;
    end else if (state_reg != ST_WAIT) begin
      auto_cnt_reg <= '0;
    end else begin
      auto_cnt_reg <= auto_cnt_reg + 1'b1;
    end
  end

  // Fires on the AUTO_TRIG_CYC-th WAIT_TRIG cycle
  assign force_trig = (state_reg == ST_WAIT) && (auto_cnt_reg == AW'(AUTO_TRIG_CYC - 1));
  assign auto_trig  = auto_trig_reg;
`else
  assign force_trig = 1'b0;
  assign auto_trig  = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    cnt_next       = cnt_reg;
    trig_pos_next  = trig_pos_reg;
    auto_trig_next = auto_trig_reg;
    wr_en          = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_next     = ST_ARM;
          wr_ptr_next    = '0;
          cnt_next       = '0;
          auto_trig_next = 1'b0;
        end
      end
      ST_ARM: begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == PRE_LAST) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (level_hit || force_trig) begin
          state_next     = ST_POST;
          trig_pos_next  = wr_ptr_reg;
          cnt_next       = '0;
          auto_trig_next = !level_hit;
        end
      end
      ST_POST: begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == POST_LAST) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      trig_pos_reg  <= '0;
      auto_trig_reg <= 1'b0;
      s0_reg        <= '0;
      s1_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      cnt_reg       <= cnt_next;
      trig_pos_reg  <= trig_pos_next;
      auto_trig_reg <= auto_trig_next;
      s0_reg        <= addata;
      s1_reg        <= s0_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= s0_reg;
    end
  end

  // In DONE wr_ptr points at the oldest sample of the record
  assign rd_accept = (state_reg == ST_DONE) && rd_en && !arm;
  assign rd_phys   = wr_ptr_reg + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_data_reg <= mem[rd_phys];
      end
    end
  end

endmodule
